// File: rtl/ctrl_pipe_tracker.sv
// Control pipeline tracker: carries decoded control from ID through EX, MEM and WB,
// inserting bubbles for load-use stalls and control-flow flushes, with event counters.
module ctrl_pipe_tracker #(
   parameter int REG_BITS = 4,
   parameter int LINK_REG = 15,
   parameter int CNT_BITS = 16
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                VALID_IN,
   input  logic [1:0]          ALUSRC_IN,
   input  logic [1:0]          NEWPCSRC_IN,
   input  logic                MEMWE_IN,
   input  logic                MEMRE_IN,
   input  logic                REGWE_IN,
   input  logic [1:0]          REGWRSRCSEL_IN,
   input  logic                REGWRDSTSEL_IN,
   input  logic [REG_BITS-1:0] RS_IN,
   input  logic [REG_BITS-1:0] RT_IN,
   input  logic [REG_BITS-1:0] RD_IN,
   input  logic                BRTAKEN_IN,
   output logic [1:0]          EX_ALUSRC_OUT,
   output logic [1:0]          EX_NEWPCSRC_OUT,
   output logic                EX_VALID_OUT,
   output logic                MEM_MEMWE_OUT,
   output logic                MEM_MEMRE_OUT,
   output logic                MEM_REGWE_OUT,
   output logic [REG_BITS-1:0] MEM_DSTREG_OUT,
   output logic                WB_REGWE_OUT,
   output logic [1:0]          WB_REGWRSRCSEL_OUT,
   output logic [REG_BITS-1:0] WB_DSTREG_OUT,
   output logic                STALL_OUT,
   output logic                FLUSH_OUT,
   output logic [CNT_BITS-1:0] STALLCNT_OUT,
   output logic [CNT_BITS-1:0] FLUSHCNT_OUT
);

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_JAL = 2'b01;
   localparam logic [1:0] PC_BR  = 2'b11;
   localparam logic [REG_BITS-1:0] REG_ZERO = {REG_BITS{1'b0}};
   localparam logic [REG_BITS-1:0] LINK_DST = REG_BITS'(LINK_REG);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

   // EX stage
   logic                ex_valid_q,  ex_valid_d;
   logic [1:0]          ex_alusrc_q, ex_alusrc_d;
   logic [1:0]          ex_pcsrc_q,  ex_pcsrc_d;
   logic                ex_memwe_q,  ex_memwe_d;
   logic                ex_memre_q,  ex_memre_d;
   logic                ex_regwe_q,  ex_regwe_d;
   logic [1:0]          ex_wrsrc_q,  ex_wrsrc_d;
   logic [REG_BITS-1:0] ex_dst_q,    ex_dst_d;
   // MEM stage
   logic                mem_memwe_q, mem_memwe_d;
   logic                mem_memre_q, mem_memre_d;
   logic                mem_regwe_q, mem_regwe_d;
   logic [1:0]          mem_wrsrc_q, mem_wrsrc_d;
   logic [REG_BITS-1:0] mem_dst_q,   mem_dst_d;
   // WB stage
   logic                wb_regwe_q,  wb_regwe_d;
   logic [1:0]          wb_wrsrc_q,  wb_wrsrc_d;
   logic [REG_BITS-1:0] wb_dst_q,    wb_dst_d;
   // counters
   logic [CNT_BITS-1:0] stallcnt_q,  stallcnt_d;
   logic [CNT_BITS-1:0] flushcnt_q,  flushcnt_d;

   logic                flush_s;
   logic                stall_s;
   logic                accept_s;
   logic [REG_BITS-1:0] id_dst_s;
   logic                ex_redirect_s;
   logic                ex_load_hit_s;

   // Hazard detection against the instruction currently in EX
   always_comb begin
      ex_redirect_s = 1'b0;
      case (ex_pcsrc_q)
         PC_JAL:  ex_redirect_s = 1'b1;
         PC_BR:   ex_redirect_s = BRTAKEN_IN;
         PC_SEQ:  ex_redirect_s = 1'b0;
         default: ex_redirect_s = 1'b0;
      endcase
      flush_s = ex_valid_q & ex_redirect_s;

      if (ex_dst_q != REG_ZERO) begin
         ex_load_hit_s = (ex_dst_q == RS_IN) | (ex_dst_q == RT_IN);
      end else begin
         ex_load_hit_s = 1'b0;
      end
      stall_s  = ~flush_s & VALID_IN & ex_valid_q & ex_memre_q & ex_regwe_q & ex_load_hit_s;
      accept_s = VALID_IN & ~flush_s & ~stall_s;
   end

   // Destination register resolution for the ID instruction; JAL links to LINK_REG
   always_comb begin
      if ((NEWPCSRC_IN == PC_JAL) && REGWE_IN) begin
         id_dst_s = LINK_DST;
      end else if (REGWRDSTSEL_IN) begin
         id_dst_s = RD_IN;
      end else begin
         id_dst_s = RT_IN;
      end
   end

   // Next-state for the three stages; EX takes a bubble unless ID is accepted
   always_comb begin
      if (accept_s) begin
         ex_valid_d  = 1'b1;
         ex_alusrc_d = ALUSRC_IN;
         ex_pcsrc_d  = NEWPCSRC_IN;
         ex_memwe_d  = MEMWE_IN;
         ex_memre_d  = MEMRE_IN;
         ex_regwe_d  = REGWE_IN;
         ex_wrsrc_d  = REGWRSRCSEL_IN;
         ex_dst_d    = id_dst_s;
      end else begin
         ex_valid_d  = 1'b0;
         ex_alusrc_d = 2'b00;
         ex_pcsrc_d  = PC_SEQ;
         ex_memwe_d  = 1'b0;
         ex_memre_d  = 1'b0;
         ex_regwe_d  = 1'b0;
         ex_wrsrc_d  = 2'b00;
         ex_dst_d    = REG_ZERO;
      end
      mem_memwe_d = ex_memwe_q;
      mem_memre_d = ex_memre_q;
      mem_regwe_d = ex_regwe_q;
      mem_wrsrc_d = ex_wrsrc_q;
      mem_dst_d   = ex_dst_q;
      wb_regwe_d  = mem_regwe_q;
      wb_wrsrc_d  = mem_wrsrc_q;
      wb_dst_d    = mem_dst_q;
   end

   // Saturating stall/flush event counters
   always_comb begin
      if (stall_s && (stallcnt_q != CNT_MAX)) begin
         stallcnt_d = stallcnt_q + CNT_ONE;
      end else begin
         stallcnt_d = stallcnt_q;
      end
      if (flush_s && (flushcnt_q != CNT_MAX)) begin
         flushcnt_d = flushcnt_q + CNT_ONE;
      end else begin
         flushcnt_d = flushcnt_q;
      end
   end

   // Stage and counter registers; reset empties every stage
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ex_valid_q  <= 1'b0;
         ex_alusrc_q <= 2'b00;
         ex_pcsrc_q  <= PC_SEQ;
         ex_memwe_q  <= 1'b0;
         ex_memre_q  <= 1'b0;
         ex_regwe_q  <= 1'b0;
         ex_wrsrc_q  <= 2'b00;
         ex_dst_q    <= REG_ZERO;
         mem_memwe_q <= 1'b0;
         mem_memre_q <= 1'b0;
         mem_regwe_q <= 1'b0;
         mem_wrsrc_q <= 2'b00;
         mem_dst_q   <= REG_ZERO;
         wb_regwe_q  <= 1'b0;
         wb_wrsrc_q  <= 2'b00;
         wb_dst_q    <= REG_ZERO;
         stallcnt_q  <= {CNT_BITS{1'b0}};
         flushcnt_q  <= {CNT_BITS{1'b0}};
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_alusrc_q <= ex_alusrc_d;
         ex_pcsrc_q  <= ex_pcsrc_d;
         ex_memwe_q  <= ex_memwe_d;
         ex_memre_q  <= ex_memre_d;
         ex_regwe_q  <= ex_regwe_d;
         ex_wrsrc_q  <= ex_wrsrc_d;
         ex_dst_q    <= ex_dst_d;
         mem_memwe_q <= mem_memwe_d;
         mem_memre_q <= mem_memre_d;
         mem_regwe_q <= mem_regwe_d;
         mem_wrsrc_q <= mem_wrsrc_d;
         mem_dst_q   <= mem_dst_d;
         wb_regwe_q  <= wb_regwe_d;
         wb_wrsrc_q  <= wb_wrsrc_d;
         wb_dst_q    <= wb_dst_d;
         stallcnt_q  <= stallcnt_d;
         flushcnt_q  <= flushcnt_d;
      end
   end

   assign EX_ALUSRC_OUT      = ex_alusrc_q;
   assign EX_NEWPCSRC_OUT    = ex_pcsrc_q;
   assign EX_VALID_OUT       = ex_valid_q;
   assign MEM_MEMWE_OUT      = mem_memwe_q;
   assign MEM_MEMRE_OUT      = mem_memre_q;
   assign MEM_REGWE_OUT      = mem_regwe_q;
   assign MEM_DSTREG_OUT     = mem_dst_q;
   assign WB_REGWE_OUT       = wb_regwe_q;
   assign WB_REGWRSRCSEL_OUT = wb_wrsrc_q;
   assign WB_DSTREG_OUT      = wb_dst_q;
   assign STALL_OUT          = stall_s;
   assign FLUSH_OUT          = flush_s;
   assign STALLCNT_OUT       = stallcnt_q;
   assign FLUSHCNT_OUT       = flushcnt_q;

endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
// Scoreboard bench for ctrl_pipe_tracker: a queue-based pipeline model predicts every
// output each cycle; a negedge monitor pops predictions and compares against the DUT.
module tb_ctrl_pipe_tracker;

   localparam int RB = 4;
   localparam int LR = 15;
   localparam int CB = 4;

   typedef struct packed {
      logic       v;
      logic [1:0] alusrc;
      logic [1:0] pcsrc;
      logic       memwe;
      logic       memre;
      logic       regwe;
      logic [1:0] wrsrc;
      logic       dstsel;
      logic [3:0] rs;
      logic [3:0] rt;
      logic [3:0] rd;
   } id_t;

   typedef struct packed {
      logic       v;
      logic [1:0] alusrc;
      logic [1:0] pcsrc;
      logic       memwe;
      logic       memre;
      logic       regwe;
      logic [1:0] wrsrc;
      logic [3:0] dst;
   } stage_t;

   logic CLOCK = 1'b0;
   logic RESET;
   logic VALID_IN, MEMWE_IN, MEMRE_IN, REGWE_IN, REGWRDSTSEL_IN, BRTAKEN_IN;
   logic [1:0] ALUSRC_IN, NEWPCSRC_IN, REGWRSRCSEL_IN;
   logic [RB-1:0] RS_IN, RT_IN, RD_IN;
   logic [1:0] EX_ALUSRC_OUT, EX_NEWPCSRC_OUT, WB_REGWRSRCSEL_OUT;
   logic EX_VALID_OUT, MEM_MEMWE_OUT, MEM_MEMRE_OUT, MEM_REGWE_OUT, WB_REGWE_OUT;
   logic STALL_OUT, FLUSH_OUT;
   logic [RB-1:0] MEM_DSTREG_OUT, WB_DSTREG_OUT;
   logic [CB-1:0] STALLCNT_OUT, FLUSHCNT_OUT;

   ctrl_pipe_tracker #(.REG_BITS(RB), .LINK_REG(LR), .CNT_BITS(CB)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .VALID_IN(VALID_IN), .ALUSRC_IN(ALUSRC_IN),
      .NEWPCSRC_IN(NEWPCSRC_IN), .MEMWE_IN(MEMWE_IN), .MEMRE_IN(MEMRE_IN),
      .REGWE_IN(REGWE_IN), .REGWRSRCSEL_IN(REGWRSRCSEL_IN), .REGWRDSTSEL_IN(REGWRDSTSEL_IN),
      .RS_IN(RS_IN), .RT_IN(RT_IN), .RD_IN(RD_IN), .BRTAKEN_IN(BRTAKEN_IN),
      .EX_ALUSRC_OUT(EX_ALUSRC_OUT), .EX_NEWPCSRC_OUT(EX_NEWPCSRC_OUT),
      .EX_VALID_OUT(EX_VALID_OUT), .MEM_MEMWE_OUT(MEM_MEMWE_OUT),
      .MEM_MEMRE_OUT(MEM_MEMRE_OUT), .MEM_REGWE_OUT(MEM_REGWE_OUT),
      .MEM_DSTREG_OUT(MEM_DSTREG_OUT), .WB_REGWE_OUT(WB_REGWE_OUT),
      .WB_REGWRSRCSEL_OUT(WB_REGWRSRCSEL_OUT), .WB_DSTREG_OUT(WB_DSTREG_OUT),
      .STALL_OUT(STALL_OUT), .FLUSH_OUT(FLUSH_OUT),
      .STALLCNT_OUT(STALLCNT_OUT), .FLUSHCNT_OUT(FLUSHCNT_OUT)
   );

   always #5 CLOCK = ~CLOCK;

   // scoreboard
   logic [28:0] expq[$];
   int          cyc_q[$];
   int          n_pass = 0;
   int          n_total = 0;
   int          cycle = 0;

   // model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
   stage_t pipe[$];
   int     m_scnt, m_fcnt;
   bit     last_stall;

   function automatic id_t mk(input logic v, input logic [1:0] alusrc, input logic [1:0] pcsrc,
                              input logic memwe, input logic memre, input logic regwe,
                              input logic [1:0] wrsrc, input logic dstsel,
                              input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
      id_t r;
      r.v = v; r.alusrc = alusrc; r.pcsrc = pcsrc; r.memwe = memwe; r.memre = memre;
      r.regwe = regwe; r.wrsrc = wrsrc; r.dstsel = dstsel; r.rs = rs; r.rt = rt; r.rd = rd;
      return r;
   endfunction

   task automatic model_reset();
      stage_t b;
      b = '0;
      pipe = {b, b, b};
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   task automatic step(input id_t ins, input logic br, input logic rst);
      stage_t ex, ent;
      bit f, s;
      logic [28:0] e;
      VALID_IN = ins.v; ALUSRC_IN = ins.alusrc; NEWPCSRC_IN = ins.pcsrc;
      MEMWE_IN = ins.memwe; MEMRE_IN = ins.memre; REGWE_IN = ins.regwe;
      REGWRSRCSEL_IN = ins.wrsrc; REGWRDSTSEL_IN = ins.dstsel;
      RS_IN = ins.rs; RT_IN = ins.rt; RD_IN = ins.rd; BRTAKEN_IN = br; RESET = rst;
      ex = pipe[0];
      f = ex.v && (ex.pcsrc == 2'b01 || (ex.pcsrc == 2'b11 && br));
      s = !f && ins.v && ex.v && ex.memre && ex.regwe && ex.dst != 4'd0 &&
          (ex.dst == ins.rs || ex.dst == ins.rt);
      last_stall = s;
      e = {pipe[0].alusrc, pipe[0].pcsrc, pipe[0].v,
           pipe[1].memwe, pipe[1].memre, pipe[1].regwe, pipe[1].dst,
           pipe[2].regwe, pipe[2].wrsrc, pipe[2].dst,
           s, f, 4'(m_scnt), 4'(m_fcnt)};
      expq.push_back(e);
      cyc_q.push_back(cycle);
      @(posedge CLOCK);
      cycle++;
      if (rst) begin
         model_reset();
      end else begin
         ent = '0;
         if (ins.v && !f && !s) begin
            ent.v = 1'b1; ent.alusrc = ins.alusrc; ent.pcsrc = ins.pcsrc;
            ent.memwe = ins.memwe; ent.memre = ins.memre; ent.regwe = ins.regwe;
            ent.wrsrc = ins.wrsrc;
            ent.dst = (ins.pcsrc == 2'b01 && ins.regwe) ? 4'(LR) : (ins.dstsel ? ins.rd : ins.rt);
         end
         pipe.push_front(ent);
         void'(pipe.pop_back());
         if (s) m_scnt = (m_scnt < 15) ? m_scnt + 1 : 15;
         if (f) m_fcnt = (m_fcnt < 15) ? m_fcnt + 1 : 15;
      end
      #1;
   endtask

   // monitor: compare every presented output set against the oldest prediction
   always @(negedge CLOCK) begin
      logic [28:0] act, exp_v;
      int c;
      if (expq.size() > 0) begin
         exp_v = expq.pop_front();
         c = cyc_q.pop_front();
         act = {EX_ALUSRC_OUT, EX_NEWPCSRC_OUT, EX_VALID_OUT,
                MEM_MEMWE_OUT, MEM_MEMRE_OUT, MEM_REGWE_OUT, MEM_DSTREG_OUT,
                WB_REGWE_OUT, WB_REGWRSRCSEL_OUT, WB_DSTREG_OUT,
                STALL_OUT, FLUSH_OUT, STALLCNT_OUT, FLUSHCNT_OUT};
         n_total++;
         if (act === exp_v) begin
            n_pass++;
         end else begin
            $display("FAIL outputs@cycle%0d actual=%h required=%h", c, act, exp_v);
         end
      end
   end

   id_t nop, addi, lw5, alur5, lw0, alur0, beq, jal, lw7, use7, lwbr7, sw, ins;
   logic br;

   initial begin
      nop   = '0;
      addi  = mk(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 4'd1, 4'd3, 4'd0);
      lw5   = mk(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd2, 4'd5, 4'd0);
      alur5 = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'd5, 4'd6, 4'd8);
      lw0   = mk(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd2, 4'd0, 4'd0);
      alur0 = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'd0, 4'd0, 4'd9);
      beq   = mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd1, 4'd2, 4'd0);
      jal   = mk(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 4'd0, 4'd0);
      lw7   = mk(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd1, 4'd7, 4'd0);
      use7  = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'd3, 4'd7, 4'd4);
      lwbr7 = mk(1'b1, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd1, 4'd7, 4'd0);
      sw    = mk(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd1, 4'd2, 4'd0);

      VALID_IN = 1'b0; ALUSRC_IN = 2'b00; NEWPCSRC_IN = 2'b00; MEMWE_IN = 1'b0;
      MEMRE_IN = 1'b0; REGWE_IN = 1'b0; REGWRSRCSEL_IN = 2'b00; REGWRDSTSEL_IN = 1'b0;
      RS_IN = '0; RT_IN = '0; RD_IN = '0; BRTAKEN_IN = 1'b0; RESET = 1'b1;
      @(posedge CLOCK);
      #1;
      model_reset();
      step(nop, 1'b0, 1'b1);

      // ADDI writes back after three edges
      step(addi, 1'b0, 1'b0);
      repeat (4) step(nop, 1'b0, 1'b0);
      // load-use stall, ID held one cycle; then register 0 never stalls
      step(lw5, 1'b0, 1'b0);
      step(alur5, 1'b0, 1'b0);
      step(alur5, 1'b0, 1'b0);
      step(lw0, 1'b0, 1'b0);
      step(alur0, 1'b0, 1'b0);
      repeat (4) step(nop, 1'b0, 1'b0);
      // taken and not-taken branch
      step(beq, 1'b0, 1'b0);
      step(addi, 1'b1, 1'b0);
      repeat (4) step(nop, 1'b1, 1'b0);
      step(beq, 1'b1, 1'b0);
      step(addi, 1'b0, 1'b0);
      repeat (4) step(nop, 1'b1, 1'b0);
      // JAL flushes regardless of BRTAKEN and links to LINK_REG
      step(jal, 1'b1, 1'b0);
      step(addi, 1'b0, 1'b0);
      repeat (4) step(nop, 1'b0, 1'b0);
      // plain LW with BRTAKEN high stalls; load carrying branch code: flush wins
      step(lw7, 1'b0, 1'b0);
      step(use7, 1'b1, 1'b0);
      step(use7, 1'b1, 1'b0);
      step(lwbr7, 1'b0, 1'b0);
      step(use7, 1'b1, 1'b0);
      step(use7, 1'b0, 1'b0);
      repeat (4) step(nop, 1'b0, 1'b0);
      // reset mid-flight discards SW in MEM and LW in EX
      step(sw, 1'b0, 1'b0);
      step(lw5, 1'b0, 1'b0);
      step(nop, 1'b0, 1'b1);
      repeat (4) step(nop, 1'b0, 1'b0);
      // drive the stall counter into saturation
      for (int k = 0; k < 20; k++) begin
         step(lw5, 1'b0, 1'b0);
         step(alur5, 1'b0, 1'b0);
         step(alur5, 1'b0, 1'b0);
      end
      repeat (3) step(nop, 1'b0, 1'b0);

      // randomized traffic; ID is held while a stall is reported
      last_stall = 1'b0;
      ins = nop;
      for (int k = 0; k < 3000; k++) begin
         if (!last_stall) begin
            ins.v      = ($urandom_range(0, 9) < 8);
            ins.alusrc = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
               0:       ins.pcsrc = 2'b01;
               1:       ins.pcsrc = 2'b11;
               default: ins.pcsrc = 2'b00;
            endcase
            ins.memwe  = ($urandom_range(0, 3) == 0);
            ins.memre  = ($urandom_range(0, 2) == 0);
            ins.regwe  = ($urandom_range(0, 3) != 0);
            ins.wrsrc  = 2'($urandom_range(0, 3));
            ins.dstsel = 1'($urandom_range(0, 1));
            ins.rs     = 4'($urandom_range(0, 3));
            ins.rt     = 4'($urandom_range(0, 3));
            ins.rd     = 4'($urandom_range(0, 3));
         end
         br = 1'($urandom_range(0, 1));
         step(ins, br, ($urandom_range(0, 199) == 0));
      end

      @(negedge CLOCK);
      #1;
      n_total++;
      if (expq.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
